// File: rtl/sprite_rom_arbiter_if.sv
// Request, grant and ROM-return signals shared between the sprite requesters and the arbiter.
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8
);
    logic                    i_flush;
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*ADDR_W-1:0] i_addr;
    logic [N_REQ-1:0]        o_gnt;
    logic                    o_rom_en;
    logic [ADDR_W-1:0]       o_rom_addr;
    logic                    i_rom_data;
    logic [N_REQ-1:0]        o_valid;
    logic [N_REQ-1:0]        o_color;

    modport master (
        output i_flush,
        output i_req,
        output i_addr,
        output i_rom_data,
        input  o_gnt,
        input  o_rom_en,
        input  o_rom_addr,
        input  o_valid,
        input  o_color
    );

    modport slave (
        input  i_flush,
        input  i_req,
        input  i_addr,
        input  i_rom_data,
        output o_gnt,
        output o_rom_en,
        output o_rom_addr,
        output o_valid,
        output o_color
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between the game's sprite requesters.
// One read in flight; returned pixels are steered back by a registered copy of the grant.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_rom_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  gnt_d;
    logic              rom_en_q;
    logic              rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [N_REQ-1:0]  tag_q;
    logic [N_REQ-1:0]  tag_d;
    logic [N_REQ-1:0]  color_q;
    logic [N_REQ-1:0]  color_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;

    logic [N_REQ-1:0]  cand_s;
    logic              win_found_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [N_REQ-1:0]  color_cap_s;

    // Scans downward so the candidate closest to the pointer is the last one written.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [N_REQ-1:0] cand,
        input logic [PTR_W-1:0] start
    );
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_REQ;
            if (cand[PTR_W'(idx)]) begin
                res = {1'b1, PTR_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // The requester shown on o_gnt this cycle sits out the next search.
    always_comb begin
        cand_s                   = bus.i_req & ~gnt_q;
        {win_found_s, win_idx_s} = rr_pick(cand_s, ptr_q);
    end

    always_comb begin
        win_addr_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            win_addr_s = (win_idx_s == PTR_W'(k)) ? bus.i_addr[k*ADDR_W +: ADDR_W] : win_addr_s;
        end
    end

    // Returning pixel is visible on o_color in the same cycle as its o_valid pulse.
    always_comb begin
        color_cap_s = (color_q & ~tag_q) | (tag_q & {N_REQ{bus.i_rom_data}});
    end

    always_comb begin
        gnt_d      = '0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        tag_d      = gnt_q;
        ptr_d      = ptr_q;
        color_d    = color_cap_s;
        if (bus.i_flush) begin
            tag_d   = '0;
            ptr_d   = '0;
            color_d = '0;
        end else if (win_found_s) begin
            gnt_d      = N_REQ'(1'b1) << win_idx_s;
            rom_en_d   = 1'b1;
            rom_addr_d = win_addr_s;
            ptr_d      = (win_idx_s == PTR_W'(N_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1'b1);
        end else begin
            gnt_d    = '0;
            rom_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            tag_q      <= '0;
            color_q    <= '0;
            ptr_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            tag_q      <= tag_d;
            color_q    <= color_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.o_gnt      = gnt_q;
    assign bus.o_rom_en   = rom_en_q;
    assign bus.o_rom_addr = rom_addr_q;
    assign bus.o_valid    = tag_q;
    assign bus.o_color    = color_cap_s;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of round-robin grants and one-cycle ROM returns.
module tb_sprite_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: data for the address shown in one cycle appears in the next.
    logic rom_mem [256];
    always @(posedge clk) bus.i_rom_data <= rom_mem[bus.o_rom_addr];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int            m_p     = 0;
    int            m_last  = -1;
    logic [N-1:0]  m_gnt   = '0;
    logic          m_en    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [N-1:0]  m_valid = '0;
    logic [N-1:0]  m_color = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // What the outputs must show during the cycle after this edge.
    task automatic model_step();
        int pend;
        int win;
        int k;
        logic [AW-1:0] prev_addr;
        if (!rst_n) begin
            m_p = 0; m_last = -1; m_gnt = '0; m_en = 1'b0;
            m_addr = '0; m_valid = '0; m_color = '0;
        end else if (bus.i_flush) begin
            m_p = 0; m_last = -1; m_gnt = '0; m_en = 1'b0;
            m_valid = '0; m_color = '0;
        end else begin
            pend      = m_last;
            prev_addr = m_addr;
            m_valid   = '0;
            if (pend >= 0) begin
                m_valid[pend] = 1'b1;
                m_color[pend] = rom_mem[prev_addr];
            end
            win = -1;
            for (int i = 0; i < N; i++) begin
                k = (m_p + i) % N;
                if (win < 0 && bus.i_req[k] && k != m_last) win = k;
            end
            m_gnt = '0;
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                m_en       = 1'b1;
                m_addr     = bus.i_addr[win*AW +: AW];
                m_p        = (win + 1) % N;
                m_last     = win;
            end else begin
                m_en   = 1'b0;
                m_last = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("gnt", 32'(bus.o_gnt), 32'(m_gnt));
                check("rom_en", 32'(bus.o_rom_en), 32'(m_en));
                check("rom_addr", 32'(bus.o_rom_addr), 32'(m_addr));
                check("valid", 32'(bus.o_valid), 32'(m_valid));
                check("color", 32'(bus.o_color), 32'(m_color));
            end
        end
    end

    initial begin
        int cnt1;
        int cnt3;
        int last1;
        int last3;
        int gap_max;
        int found;
        logic [N-1:0] seen;

        rst_n       = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_req   = '0;
        bus.i_addr  = '0;
        for (int a = 0; a < 256; a++) rom_mem[a] = 1'($urandom_range(0, 1));
        rom_mem[8'h2A] = 1'b1;

        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_gnt", 32'(bus.o_gnt), 32'h0);
        check("rst_en", 32'(bus.o_rom_en), 32'h0);
        check("rst_addr", 32'(bus.o_rom_addr), 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_color", 32'(bus.o_color), 32'h0);

        // Lone requester: granted on odd cycles, pixel back on even cycles.
        bus.i_addr = {24'($urandom), 8'h2A};
        bus.i_req  = 4'b0001;
        rst_n      = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c % 2 == 1) begin
                check("single_gnt", 32'(bus.o_gnt), 32'h1);
                check("single_addr", 32'(bus.o_rom_addr), 32'h2A);
                check("single_valid_odd", 32'(bus.o_valid), 32'h0);
            end else begin
                check("single_gnt_even", 32'(bus.o_gnt), 32'h0);
                check("single_valid", 32'(bus.o_valid), 32'h1);
                check("single_color", 32'(bus.o_color[0]), 32'h1);
            end
        end
        bus.i_req = 4'b0000;
        tick();
        check("idle_gnt", 32'(bus.o_gnt), 32'h0);
        check("idle_en", 32'(bus.o_rom_en), 32'h0);
        check("idle_addr_hold", 32'(bus.o_rom_addr), 32'h2A);
        tick();
        check("idle_color_hold", 32'(bus.o_color[0]), 32'h1);

        // All requesting from reset: 0,1,2,3,0,...
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n      = 1'b1;
        bus.i_addr = $urandom;
        bus.i_req  = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("rr_order", 32'(bus.o_gnt), 32'(4'b0001 << ((c - 1) % 4)));
            check("rr_valid", 32'(bus.o_valid), (c == 1) ? 32'h0 : 32'(4'b0001 << ((c - 2) % 4)));
        end

        // Flush while requester 2 holds the grant.
        found = 0;
        for (int c = 0; c < 8 && found == 0; c++) begin
            tick();
            if (m_gnt == 4'b0100) found = 1;
        end
        check("flush_reach_gnt2", 32'(found), 32'h1);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("flush_gnt", 32'(bus.o_gnt), 32'h0);
        check("flush_valid", 32'(bus.o_valid), 32'h0);
        check("flush_color", 32'(bus.o_color), 32'h0);
        tick();
        check("flush_next_gnt", 32'(bus.o_gnt), 32'h1);
        check("flush_no_valid2", 32'(bus.o_valid), 32'h0);

        // Reset while a read is in flight.
        check("rstmid_en_before", 32'(bus.o_rom_en), 32'h1);
        rst_n = 1'b0;
        tick();
        check("rstmid_gnt", 32'(bus.o_gnt), 32'h0);
        check("rstmid_en", 32'(bus.o_rom_en), 32'h0);
        check("rstmid_addr", 32'(bus.o_rom_addr), 32'h0);
        check("rstmid_valid", 32'(bus.o_valid), 32'h0);
        check("rstmid_color", 32'(bus.o_color), 32'h0);
        rst_n = 1'b1;

        // Requester 1 drops its request after losing to requester 0.
        bus.i_req = 4'b0011;
        tick();
        check("drop_win0", 32'(bus.o_gnt), 32'h1);
        bus.i_req = 4'b0001;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | bus.o_gnt;
        end
        check("drop_never_gnt1", 32'(seen[1]), 32'h0);

        // Fairness between requesters 1 and 3.
        bus.i_req   = 4'b0000;
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_req   = 4'b1010;
        cnt1 = 0; cnt3 = 0; last1 = 0; last3 = 0; gap_max = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus.o_gnt[1]) begin
                cnt1++;
                if (c - last1 > gap_max) gap_max = c - last1;
                last1 = c;
            end
            if (bus.o_gnt[3]) begin
                cnt3++;
                if (c - last3 > gap_max) gap_max = c - last3;
                last3 = c;
            end
        end
        check("fair_cnt1", 32'(cnt1 >= 49 && cnt1 <= 51), 32'h1);
        check("fair_cnt3", 32'(cnt3 >= 49 && cnt3 <= 51), 32'h1);
        check("fair_gap", 32'(gap_max <= 2), 32'h1);

        // Randomized traffic: mostly held requests, occasional drops, flushes and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.i_req = 4'($urandom);
            else bus.i_req = bus.i_req & ~m_gnt;
            bus.i_addr  = $urandom;
            bus.i_flush = ($urandom_range(0, 31) == 0);
            rst_n       = ($urandom_range(0, 199) != 0);
            tick();
        end
        bus.i_flush = 1'b0;
        rst_n       = 1'b1;
        bus.i_req   = 4'b0000;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4; number of requesters (0 dino, 1 obstacle 1, 2 obstacle 2, 3 background object).
REQ-002 Parameter ADDR_W, default 8; width of the sprite ROM address.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port i_flush  input  1  pulse (game start); drops all pending and in-flight work.
REQ-006 Port i_req  input  N_REQ  per-requester read request; level, held until granted.
REQ-007 Port i_addr  input  N_REQ*ADDR_W  flattened addresses, requester k at bits [k*ADDR_W +: ADDR_W]; stable while i_req[k]=1.
REQ-008 Port o_gnt  output  N_REQ  one-hot grant pulse, registered.
REQ-009 Port o_rom_en  output  1  ROM read strobe, registered.
REQ-010 Port o_rom_addr  output  ADDR_W  ROM address, registered; valid when o_rom_en=1.
REQ-011 Port i_rom_data  input  1  ROM pixel colour; valid exactly one cycle after o_rom_en=1.
REQ-012 Port o_valid  output  N_REQ  one-hot pulse marking a returned pixel for requester k.
REQ-013 Port o_color  output  N_REQ  per-requester held pixel colour, updated only on its return.

Function
REQ-014 Arbitration: each cycle, if any i_req bit is set, the block SHALL select one requester by round-robin, starting the search at pointer p and wrapping from N_REQ-1 to 0.
REQ-015 Pointer p SHALL update to (winner+1) mod N_REQ after every grant and SHALL be unchanged in cycles with no grant.
REQ-016 Masking: a requester that was granted in the previous cycle SHALL be excluded from the search in the current cycle. If it is the only requester, it SHALL be granted every other cycle.
REQ-017 Latency: a decision made at edge t SHALL appear as o_gnt[k]=1, o_rom_en=1 and o_rom_addr=i_addr[k] during cycle t+1.
REQ-018 Pipeline: i_rom_data SHALL be captured at edge t+2, and o_color[k] and o_valid[k] SHALL reflect that capture during cycle t+2.
REQ-019 One grant per cycle: at most one o_gnt bit and at most one o_valid bit SHALL be set in any cycle; o_rom_en SHALL equal |o_gnt.
REQ-020 Returns SHALL be tagged with a one-stage registered copy of o_gnt. The pipeline SHALL hold at most one read in flight and SHALL NOT stall.
REQ-021 Idle: with i_req=0, the block SHALL drive o_gnt=0 and o_rom_en=0, and o_rom_addr SHALL hold its last value.
REQ-022 Flush: an i_flush at edge t SHALL clear o_gnt, o_rom_en and the return tag, SHALL reset p to 0, and SHALL suppress the o_valid that a grant issued in cycle t would otherwise produce.
REQ-023 Flush also SHALL clear o_color to 0, and SHALL make no arbitration decision at edge t.
REQ-024 Flush with request: if i_flush and i_req are both asserted at edge t, i_flush SHALL win. Arbitration SHALL resume at edge t+1 with p=0.
REQ-025 Request drop: if i_req[k] deasserts before it is granted, no grant SHALL be issued to k. A grant already registered SHALL still complete and return its data.
REQ-026 Unused bits: i_addr bits of non-requesting requesters SHALL be ignored. o_rom_addr SHALL never mix bits from two requesters.

Reset
REQ-027 On rst_n=0 at a clock edge, the block SHALL force o_gnt=0, o_rom_en=0, o_rom_addr=0, o_valid=0 and o_color=0.
REQ-028 The same reset SHALL force p=0, clear the return tag and clear the previous-grant mask.
REQ-029 Reset asserted mid-transaction SHALL discard the in-flight read; no o_valid SHALL occur for it.
REQ-030 The first arbitration after reset SHALL occur at the first edge with rst_n=1.

Verification
REQ-031 Single requester: i_req=4'b0001 held, i_addr[7:0]=8'h2A, ROM returns 1 -> o_gnt=0001 and o_rom_addr=2A in cycles 1, 3, 5...; o_valid[0]=1 and o_color[0]=1 in cycles 2, 4, 6...
REQ-032 All request after reset: i_req=4'b1111 held -> grant order 0,1,2,3,0,... with one grant per cycle; each o_valid[k] appears one cycle after o_gnt[k].
REQ-033 Fairness: requesters 1 and 3 held for 100 cycles -> they alternate, with each granted 50±1 times and no gap of more than 2 cycles between grants to either.
REQ-034 Flush mid-stream: i_req=1111 with i_flush pulsed while o_gnt=0100 -> no o_valid[2] follows; o_color=0; the next grant after i_flush goes to requester 0.
REQ-035 Reset mid-read: rst_n=0 in the cycle with o_rom_en=1 -> o_valid stays 0 and all outputs read 0 the next cycle.
REQ-036 Request drop: i_req[1] pulsed for 1 cycle while requester 0 wins the same edge -> requester 1 is never granted and o_gnt[1] stays 0.
